// File: rtl/fifo_uart_tx.sv
// Drain-side consumer for the 8-bit synchronous TX FIFO: pops one byte at a time
// and serializes it as an 8N1 UART frame (start, 8 data LSB first, stop).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_end;

    assign bit_end = (bit_cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tx_enable && !fifo_empty) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_START;
            S_START: if (bit_end) state_nxt = S_DATA;
            S_DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = S_STOP;
            S_STOP:  if (bit_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // tx follows the current state one register later, so the line falls one
    // cycle into START and the post-frame gap covers IDLE, FETCH and LATCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'd0;
            fifo_rd_en <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            fifo_rd_en <= (state_nxt == S_FETCH);
            busy       <= (state_nxt != S_IDLE);
            tx_done    <= (state == S_STOP) && bit_end;

            // FIFO read data is valid one cycle after the read strobe.
            if (state == S_LATCH) begin
                shift <= fifo_data;
            end

            if ((state == S_START) || (state == S_DATA) || (state == S_STOP)) begin
                bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
            end

            if (state != S_DATA) begin
                bit_idx <= 3'd0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            case (state)
                S_START: tx <= 1'b0;
                S_DATA:  tx <= shift[bit_idx];
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a small behavioural
// FIFO (one-cycle registered read) feeding the design.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'd0;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         rd_pulses = 0;
    int         done_pulses = 0;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1 && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1) rd_pulses <= rd_pulses + 1;
        if (tx_done === 1'b1)    done_pulses <= done_pulses + 1;
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Waits for the start bit, then samples every cycle of the 10-bit frame.
    // gap returns the number of high samples seen before the start bit.
    task automatic decode_frame(input logic [7:0] exp, input string name,
                                input int drop_at, output int gap);
        logic [9:0] fb;
        logic       found;
        logic       bad;
        fb    = {1'b1, exp, 1'b0};
        gap   = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
            else gap++;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s_start: tx stayed %b for %0d cycles, required a start bit", name, tx, gap);
            return;
        end
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int k = 0; k < CPB; k++) begin
                if (b > 0 || k > 0) @(negedge clk);
                if (b * CPB + k == drop_at) tx_enable = 1'b0;
                if (tx !== fb[b]) bad = 1'b1;
            end
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s_bit%0d: tx not held at %b for %0d cycles (last seen %b)", name, b, fb[b], CPB, tx);
            end
        end
    endtask

    task automatic test_reset;
        logic bad;
        reset = 1'b1;
        tx_enable = 1'b0;
        push(8'hA5);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx, busy, fifo_rd_en, tx_done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_values: tx,busy,rd_en,done=%b required 1000", {tx, busy, fifo_rd_en, tx_done});
        end
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({tx, busy, fifo_rd_en} !== 3'b100) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_hold: tx,busy,rd_en=%b at end, required 100 for 50 cycles", {tx, busy, fifo_rd_en});
        end
        n_checks++;
        if (rd_pulses !== 0) begin
            n_fail++;
            $display("FAIL reset_no_read: rd pulses %0d required 0", rd_pulses);
        end
    endtask

    task automatic test_single;
        int rd0, dn0, gap;
        rd0 = rd_pulses;
        dn0 = done_pulses;
        tx_enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fifo_rd_en, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL single_fetch: rd_en,busy=%b required 11", {fifo_rd_en, busy});
        end
        decode_frame(8'hA5, "single", -1, gap);
        n_checks++;
        if (gap !== 2) begin
            n_fail++;
            $display("FAIL single_latency: %0d high cycles after fetch, required 2", gap);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_pulses - rd0 !== 1 || done_pulses - dn0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: reads %0d done %0d busy %b, required 1 1 0",
                     rd_pulses - rd0, done_pulses - dn0, busy);
        end
    endtask

    task automatic test_back_to_back;
        int rd0, gap;
        rd0 = rd_pulses;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        decode_frame(8'h00, "b2b0", -1, gap);
        decode_frame(8'hFF, "b2b1", -1, gap);
        n_checks++;
        if (gap !== 3) begin
            n_fail++;
            $display("FAIL b2b_gap1: gap %0d cycles required 3", gap);
        end
        decode_frame(8'h3C, "b2b2", -1, gap);
        n_checks++;
        if (gap !== 3) begin
            n_fail++;
            $display("FAIL b2b_gap2: gap %0d cycles required 3", gap);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (rd_pulses - rd0 !== 3) begin
            n_fail++;
            $display("FAIL b2b_reads: %0d read pulses required 3", rd_pulses - rd0);
        end
    endtask

    task automatic test_empty;
        int  rd0;
        logic bad;
        rd0 = rd_pulses;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || rd_pulses - rd0 !== 0) begin
            n_fail++;
            $display("FAIL empty_idle: reads %0d tx %b busy %b, required 0 1 0", rd_pulses - rd0, tx, busy);
        end
    endtask

    task automatic test_enable_drop;
        int rd0, dn0, gap;
        rd0 = rd_pulses;
        dn0 = done_pulses;
        push(8'h55);
        push(8'hAA);
        // sample 17 lies in data bit 3 (frame bit 4)
        decode_frame(8'h55, "drop", 4 * CPB + 1, gap);
        repeat (20) @(negedge clk);
        n_checks++;
        if (rd_pulses - rd0 !== 1 || done_pulses - dn0 !== 1) begin
            n_fail++;
            $display("FAIL drop_counts: reads %0d done %0d required 1 1", rd_pulses - rd0, done_pulses - dn0);
        end
        n_checks++;
        if (wr_ptr - rd_ptr !== 1 || tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_left: fifo level %0d tx %b busy %b, required 1 1 0", wr_ptr - rd_ptr, tx, busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        int   rd0, dn0, gap;
        logic found;
        wr_ptr = rd_ptr;
        rd0 = rd_pulses;
        dn0 = done_pulses;
        push(8'h0F);
        push(8'h96);
        tx_enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        // 24 samples past the start edge is data bit 5 of 0x0F, a zero
        repeat (6 * CPB) @(negedge clk);
        n_checks++;
        if (!found || tx !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: found %b tx %b in data bit 5, required 1 0", found, tx);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({tx, busy, fifo_rd_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_async: tx,busy,rd_en=%b required 100", {tx, busy, fifo_rd_en});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        decode_frame(8'h96, "rstmid", -1, gap);
        repeat (4) @(negedge clk);
        n_checks++;
        if (rd_pulses - rd0 !== 2 || done_pulses - dn0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_end: reads %0d done %0d busy %b, required 2 1 0",
                     rd_pulses - rd0, done_pulses - dn0, busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        tx_enable = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_empty;
        test_enable_drop;
        test_reset_mid_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
